aes_sub_bytes_seq: RTL and testbench
====================================

Name: aes_sub_bytes_seq

Overview:
Round-level SubBytes sequencer for the AES-GCM datapath. It accepts a 128-bit round state and streams it word-by-word through the shared 32-bit aes_sbox instance, one word per cycle. It reassembles the four substituted words into a 128-bit result for the downstream ShiftRows stage. Valid/ready handshakes are used on both sides.

Parameters:
RND_SIZE, 128, round state width in bits
WRD_SIZE, 32, word width presented to aes_sbox
NUM_BLK, 4, words per round state (RND_SIZE/WRD_SIZE)
CNT_SIZE, 2, word counter width (log2 NUM_BLK)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_vld  input  1  upstream state valid
o_rdy  output  1  block can accept a state this cycle
i_rnd_text  input  RND_SIZE  round state in; word 0 = [127:96], word 3 = [31:0]
o_wrd_sbox_in  output  WRD_SIZE  word driven to aes_sbox i_wrd_sbox
i_wrd_sbox_out  input  WRD_SIZE  aes_sbox o_wrd_sbox return (combinational)
o_rnd_text  output  RND_SIZE  substituted state, {word0,word1,word2,word3}
o_vld  output  1  o_rnd_text valid
i_rdy  input  1  downstream accepts

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values: state=IDLE, o_vld=0, o_rdy=1, o_rnd_text=0, o_wrd_sbox_in=0. The counter and captured-state register are cleared.
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - o_rdy=1, o_wrd_sbox_in=0.
  - On i_vld: capture i_rnd_text, set cnt=0, go to SUB.
- SUB:
  - o_rdy=0.
  - o_wrd_sbox_in = captured word[cnt], driven from registers, no input path.
  - Each edge: result word[cnt] <= i_wrd_sbox_out, then cnt++.
  - The edge with cnt==NUM_BLK-1 writes word 3 and moves to DONE.
- DONE:
  - o_vld=1; o_rnd_text holds stable until the handshake completes.
  - o_rdy = i_rdy.
  - o_vld&i_rdy&!i_vld: go to IDLE.
  - o_vld&i_rdy&i_vld: capture the new state, cnt=0, go directly to SUB. This gives back-to-back operation with no idle bubble.
  - !i_rdy: stay in DONE. i_vld is ignored because o_rdy=0.
- Latency:
  - Accept edge at T; words issued to the sbox in cycles T+1..T+4.
  - o_vld rises after edge T+4.
  - Sustained throughput is one state per 5 cycles with i_rdy held high (4 SUB cycles plus 1 DONE handshake cycle).
- Capture rule: upstream may change i_rnd_text freely after the accept edge; only the captured copy is used.
- o_rnd_text update rule: the result register is written only in SUB. The previous value remains visible after the handshake and until the next word-0 write; it is meaningful only while o_vld=1.
- Counter: wraps 3->0 only via reload on accept. No other wrap occurs.
- Reset mid-operation (any state, including with o_vld=1): immediately returns to reset values. The partial result is discarded and no o_vld pulse is produced.
- Handshake: i_vld while o_rdy=0 has no effect; upstream must hold the state until it sees o_rdy.

Test Plan:
1. FIPS-197 round 1: reset, then i_rnd_text=193de3bea0f4e22b9ac68d2ae9f84808 with i_vld one cycle and i_rdy=1 -> o_wrd_sbox_in sequence 193de3be, a0f4e22b, 9ac68d2a, e9f84808; o_vld rises 4 edges after accept; o_rnd_text=d42711aee0bf98f1b8b45de51e415230.
2. Back-to-back: i_vld held high with states 0 then ffff...ff and i_rdy=1 -> outputs 6363...63 then 1616...16; second accept occurs in the DONE cycle, so o_vld pulses are spaced 5 cycles apart.
3. Backpressure: i_rdy=0 for 6 cycles after o_vld -> o_vld and o_rnd_text stay stable and o_rdy=0; a new i_vld is ignored; after i_rdy=1 for one cycle the block returns to IDLE.
4. Input change after accept: i_rnd_text switched to 0 on the edge after accept -> result still d42711ae... (from scenario 1 input).
5. Async reset mid-SUB: assert i_rst_n=0 between clock edges at cnt=2 -> o_vld=0, o_rdy=1, o_rnd_text=0 immediately; a subsequent full transaction completes correctly.
6. i_vld pulsed while in SUB -> ignored; exactly one o_vld pulse results.

Source files
------------

// File: rtl/aes_sub_bytes_seq.sv
// Round-level SubBytes sequencer: streams a captured 128-bit AES state through one
// shared 32-bit S-box, one word per cycle, and reassembles the substituted state.
module aes_sub_bytes_seq #(
    parameter int RND_SIZE = 128,
    parameter int WRD_SIZE = 32,
    parameter int NUM_BLK  = 4,
    parameter int CNT_SIZE = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_vld,
    output logic                o_rdy,
    input  logic [RND_SIZE-1:0] i_rnd_text,
    output logic [WRD_SIZE-1:0] o_wrd_sbox_in,
    input  logic [WRD_SIZE-1:0] i_wrd_sbox_out,
    output logic [RND_SIZE-1:0] o_rnd_text,
    output logic                o_vld,
    input  logic                i_rdy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid without ready has no effect and the sender must hold its data until ready.

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SUB  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [CNT_SIZE-1:0] cnt_q,   cnt_d;
    logic [RND_SIZE-1:0] cap_q,   cap_d;
    logic [RND_SIZE-1:0] res_q,   res_d;
    logic [WRD_SIZE-1:0] sbox_word;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        res_d     = res_q;
        sbox_word = '0;
        case (state_q)
            ST_IDLE: begin
                if (i_vld) begin
                    cap_d   = i_rnd_text;
                    cnt_d   = '0;
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                // Word 0 is the most significant word of the state.
                for (int k = 0; k < NUM_BLK; k++) begin
                    if (cnt_q == CNT_SIZE'(k)) begin
                        sbox_word = cap_q[RND_SIZE-1-k*WRD_SIZE -: WRD_SIZE];
                        res_d[RND_SIZE-1-k*WRD_SIZE -: WRD_SIZE] = i_wrd_sbox_out;
                    end
                end
                if (cnt_q == CNT_SIZE'(NUM_BLK-1)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (i_rdy) begin
                    if (i_vld) begin
                        // Back-to-back: take the next state in the handshake cycle.
                        cap_d   = i_rnd_text;
                        cnt_d   = '0;
                        state_d = ST_SUB;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            res_q   <= res_d;
        end
    end

    assign o_rdy         = (state_q == ST_IDLE) | ((state_q == ST_DONE) & i_rdy);
    assign o_vld         = (state_q == ST_DONE);
    assign o_wrd_sbox_in = sbox_word;
    assign o_rnd_text    = res_q;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Bench for aes_sub_bytes_seq: an arithmetic S-box model answers the DUT's S-box port,
// and a cycle-timing model plus expected queues check every output on each falling edge.
module tb_aes_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_vld = 1'b0;
  logic         o_rdy;
  logic [127:0] i_rnd_text = '0;
  logic [31:0]  o_wrd_sbox_in;
  logic [31:0]  i_wrd_sbox_out;
  logic [127:0] o_rnd_text;
  logic         o_vld;
  logic         i_rdy = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_hs = 0;

  logic [127:0] exp_q[$];
  logic [31:0]  wrd_q[$];

  aes_sub_bytes_seq dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_vld         (i_vld),
    .o_rdy         (o_rdy),
    .i_rnd_text    (i_rnd_text),
    .o_wrd_sbox_in (o_wrd_sbox_in),
    .i_wrd_sbox_out(i_wrd_sbox_out),
    .o_rnd_text    (o_rnd_text),
    .o_vld         (o_vld),
    .i_rdy         (i_rdy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = sbox(w[i*8 +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] sub_state(logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = sub_word(s[i*32 +: 32]);
    return r;
  endfunction

  assign i_wrd_sbox_out = sub_word(o_wrd_sbox_in);

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Timing model: after an accept edge the next four falling edges show words 0..3 on the
  // S-box port with both valids low; from the fifth on the result is valid until taken.
  bit active = 1'b0;
  int p = 0;

  always @(negedge clk) begin
    logic exp_rdy;
    if (!rst_n) begin
      chk("rst_o_vld", 128'(o_vld), 128'(1'b0));
      chk("rst_o_rdy", 128'(o_rdy), 128'(1'b1));
      chk("rst_o_rnd_text", o_rnd_text, 128'h0);
      chk("rst_sbox_in", 128'(o_wrd_sbox_in), 128'h0);
      exp_q.delete();
      wrd_q.delete();
      active = 1'b0;
      p = 0;
    end else begin
      exp_rdy = !active || (p >= 5 && i_rdy);
      chk("o_rdy", 128'(o_rdy), 128'(exp_rdy));
      chk("o_vld", 128'(o_vld), 128'(active && p >= 5));
      if (!active) begin
        chk("idle_sbox_in", 128'(o_wrd_sbox_in), 128'h0);
      end else if (p <= 4) begin
        if (wrd_q.size() > 0) chk("sbox_in_word", 128'(o_wrd_sbox_in), 128'(wrd_q.pop_front()));
        else chk("sbox_word_queue_empty", 128'(o_wrd_sbox_in), 128'hx);
      end else begin
        if (exp_q.size() > 0) chk("o_rnd_text", o_rnd_text, exp_q[0]);
        else chk("result_queue_empty", o_rnd_text, 128'hx);
        if (i_rdy) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          n_hs++;
          active = 1'b0;
        end
      end
      if (i_vld && exp_rdy) begin
        exp_q.push_back(sub_state(i_rnd_text));
        for (int k = 3; k >= 0; k--) wrd_q.push_back(i_rnd_text[k*32 +: 32]);
        active = 1'b1;
        p = 0;
      end
      if (active) p++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_vld = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Waits for o_vld on a falling edge, then checks the result against a known constant.
  task automatic wait_vld(string name, logic [127:0] req, output int at_cyc);
    bit seen = 1'b0;
    at_cyc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (o_vld) seen = 1'b1;
    end
    if (!seen) begin
      chk({name, "_timeout"}, 128'(o_vld), 128'(1'b1));
    end else begin
      at_cyc = cyc;
      chk(name, o_rnd_text, req);
    end
  endtask

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  initial begin
    int c0, c1, hs0;
    do_reset();

    // FIPS-197 round 1, with the input dropped to zero right after the accept edge
    i_rdy = 1'b1;
    i_vld = 1'b1;
    i_rnd_text = FIPS_IN;
    tick();
    c0 = cyc;
    i_vld = 1'b0;
    i_rnd_text = '0;
    wait_vld("fips_result", FIPS_OUT, c1);
    chk("fips_latency", 128'(c1 - c0), 128'(4));
    tick();

    // Back-to-back with i_vld held high
    i_vld = 1'b1;
    i_rnd_text = '0;
    tick();
    i_rnd_text = {128{1'b1}};
    wait_vld("b2b_zero", {16{8'h63}}, c0);
    tick();
    i_vld = 1'b0;
    wait_vld("b2b_ones", {16{8'h16}}, c1);
    chk("b2b_spacing", 128'(c1 - c0), 128'(5));
    tick();

    // Backpressure: 6 stalled cycles with a competing i_vld that must be ignored
    i_vld = 1'b1;
    i_rnd_text = FIPS_IN;
    tick();
    i_vld = 1'b0;
    i_rdy = 1'b0;
    wait_vld("bp_result", FIPS_OUT, c0);
    tick();
    i_vld = 1'b1;
    i_rnd_text = 128'h0123456789abcdef0011223344556677;
    repeat (6) tick();
    chk("bp_hold", o_rnd_text, FIPS_OUT);
    i_vld = 1'b0;
    i_rdy = 1'b1;
    tick();
    tick();

    // Async reset in the middle of SUB (cnt == 2)
    i_vld = 1'b1;
    i_rnd_text = FIPS_IN;
    tick();
    i_vld = 1'b0;
    repeat (2) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_o_vld", 128'(o_vld), 128'(1'b0));
    chk("arst_o_rdy", 128'(o_rdy), 128'(1'b1));
    chk("arst_o_rnd_text", o_rnd_text, 128'h0);
    tick();
    rst_n = 1'b1;
    i_vld = 1'b1;
    i_rnd_text = FIPS_IN;
    tick();
    i_vld = 1'b0;
    wait_vld("post_rst_result", FIPS_OUT, c0);
    tick();

    // i_vld pulsed during SUB yields exactly one result
    hs0 = n_hs;
    i_vld = 1'b1;
    i_rnd_text = 128'hfedcba98765432100f1e2d3c4b5a6978;
    tick();
    i_vld = 1'b0;
    tick();
    i_vld = 1'b1;
    i_rnd_text = 128'h11111111222222223333333344444444;
    tick();
    i_vld = 1'b0;
    repeat (8) tick();
    chk("sub_pulse_one_result", 128'(n_hs - hs0), 128'(1));

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      i_vld = 1'($urandom_range(0, 1));
      i_rdy = ($urandom_range(0, 3) != 0);
      i_rnd_text = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    i_vld = 1'b0;
    i_rdy = 1'b1;
    repeat (10) tick();
    chk("drain_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
